// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, controller
// states and the default datapath width.
package alu_pkg;

   localparam int ALU_DATA_W = 8;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_EQ
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE, S_EXEC, S_RESP
   } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result buses of the issue controller; the controller
// takes the slave side, the command source / result sink the master side.
interface alu_issue_ctrl_if #(
   parameter int DATA_W = alu_pkg::ALU_DATA_W,
   parameter int NREGS  = 4
);
   localparam int REG_AW = $clog2(NREGS);

   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic              cmd_ld_i;
   logic [2:0]        cmd_op_i;
   logic [REG_AW-1:0] cmd_rd_i;
   logic [REG_AW-1:0] cmd_rs1_i;
   logic [REG_AW-1:0] cmd_rs2_i;
   logic [DATA_W-1:0] cmd_imm_i;
   logic [DATA_W-1:0] alu_a_o;
   logic [DATA_W-1:0] alu_b_o;
   logic [2:0]        alu_op_o;
   logic [DATA_W-1:0] alu_res_i;
   logic              res_valid_o;
   logic              res_ready_i;
   logic [DATA_W-1:0] res_data_o;
   logic [REG_AW-1:0] res_rd_o;
   logic              res_zero_o;

   modport slave (
      input  cmd_valid_i, cmd_ld_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i,
             cmd_imm_i, alu_res_i, res_ready_i,
      output cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o,
             res_rd_o, res_zero_o
   );

   modport master (
      output cmd_valid_i, cmd_ld_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i,
             cmd_imm_i, alu_res_i, res_ready_i,
      input  cmd_ready_o, alu_a_o, alu_b_o, alu_op_o, res_valid_o, res_data_o,
             res_rd_o, res_zero_o
   );

endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two asynchronous read ports, one synchronous write
// port, synchronous active-low clear of every entry.
module alu_regfile #(
   parameter int DATA_W = alu_pkg::ALU_DATA_W,
   parameter int NREGS  = 4,
   localparam int REG_AW = $clog2(NREGS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: accepts load/ALU commands,
// launches operands, captures and writes back the result, and hands it downstream.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int NREGS  = 4
) (
   input logic            clk_i,
   input logic            rst_ni,
   alu_issue_ctrl_if.slave bus
);

   localparam int REG_AW = $clog2(NREGS);

   state_e            state_p0, state_nxt;
   logic              cmd_fire;
   logic [REG_AW-1:0] rd_p1;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

   assign bus.cmd_ready_o = (state_p0 == S_IDLE);
   assign cmd_fire        = bus.cmd_valid_i && bus.cmd_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_p0 <= S_IDLE;
      else         state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         S_IDLE:  if (cmd_fire && !bus.cmd_ld_i) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (bus.res_ready_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Writeback port is shared: immediates in S_IDLE, ALU results in S_EXEC.
   assign rf_we    = (cmd_fire && bus.cmd_ld_i) || (state_p0 == S_EXEC);
   assign rf_waddr = (state_p0 == S_EXEC) ? rd_p1 : bus.cmd_rd_i;
   assign rf_wdata = (state_p0 == S_EXEC) ? bus.alu_res_i : bus.cmd_imm_i;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_rf (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (bus.cmd_rs1_i),
      .raddr2 (bus.cmd_rs2_i),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // Stage 1: operand launch on accept; stage 2: result capture out of S_EXEC.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bus.alu_a_o    <= '0;
         bus.alu_b_o    <= '0;
         bus.alu_op_o   <= '0;
         rd_p1          <= '0;
         bus.res_data_o <= '0;
         bus.res_rd_o   <= '0;
      end else begin
         if (cmd_fire && !bus.cmd_ld_i) begin
            bus.alu_a_o  <= rf_rdata1;
            bus.alu_b_o  <= rf_rdata2;
            bus.alu_op_o <= bus.cmd_op_i;
            rd_p1        <= bus.cmd_rd_i;
         end
         if (state_p0 == S_EXEC) begin
            bus.res_data_o <= bus.alu_res_i;
            bus.res_rd_o   <= rd_p1;
         end
      end
   end

   assign bus.res_valid_o = (state_p0 == S_RESP);
   assign bus.res_zero_o  = (bus.res_data_o == '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random command streams
// checked against a register-file/ALU reference model.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int DATA_W = 8;
   localparam int NREGS  = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   logic [7:0] mdl_rf [NREGS];

   alu_issue_ctrl_if #(.DATA_W(DATA_W), .NREGS(NREGS)) bus ();

   alu_issue_ctrl #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLL:  return a << b[2:0];
         OP_LSR:  return a >> b[2:0];
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return (a == b) ? 8'd1 : 8'd0;
      endcase
   endfunction

   assign bus.alu_res_i = alu_fn(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rf();
      for (int i = 0; i < NREGS; i++) chk("rf", 32'(dut.u_rf.mem[i]), 32'(mdl_rf[i]));
   endtask

   task automatic scramble_cmd();
      bus.cmd_op_i  = 3'($urandom_range(0, 7));
      bus.cmd_rd_i  = 2'($urandom_range(0, 3));
      bus.cmd_rs1_i = 2'($urandom_range(0, 3));
      bus.cmd_rs2_i = 2'($urandom_range(0, 3));
      bus.cmd_imm_i = 8'($urandom_range(0, 255));
      bus.cmd_ld_i  = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NREGS; i++) mdl_rf[i] = 8'h00;
   endtask

   task automatic do_ld(input logic [1:0] rd, input logic [7:0] imm);
      chk("ld_ready", 32'(bus.cmd_ready_o), 32'd1);
      scramble_cmd();
      bus.cmd_valid_i = 1'b1;
      bus.cmd_ld_i    = 1'b1;
      bus.cmd_rd_i    = rd;
      bus.cmd_imm_i   = imm;
      tick();
      bus.cmd_valid_i = 1'b0;
      scramble_cmd();
      mdl_rf[rd] = imm;
      chk("ld_no_res", 32'(bus.res_valid_o), 32'd0);
      chk("ld_ready_next", 32'(bus.cmd_ready_o), 32'd1);
   endtask

   task automatic do_alu(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input int stall, input bit pulse,
                         output logic [7:0] res);
      logic [7:0] ea, eb, er;
      ea = mdl_rf[rs1];
      eb = mdl_rf[rs2];
      er = alu_fn(op, ea, eb);
      chk("alu_ready", 32'(bus.cmd_ready_o), 32'd1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_ld_i    = 1'b0;
      bus.cmd_op_i    = op;
      bus.cmd_rd_i    = rd;
      bus.cmd_rs1_i   = rs1;
      bus.cmd_rs2_i   = rs2;
      bus.cmd_imm_i   = 8'($urandom_range(0, 255));
      tick();
      bus.cmd_valid_i = 1'b0;
      scramble_cmd();
      chk("exec_a", 32'(bus.alu_a_o), 32'(ea));
      chk("exec_b", 32'(bus.alu_b_o), 32'(eb));
      chk("exec_op", 32'(bus.alu_op_o), 32'(op));
      chk("exec_nores", 32'(bus.res_valid_o), 32'd0);
      chk("exec_busy", 32'(bus.cmd_ready_o), 32'd0);
      tick();
      mdl_rf[rd] = er;
      chk("resp_valid", 32'(bus.res_valid_o), 32'd1);
      chk("resp_data", 32'(bus.res_data_o), 32'(er));
      chk("resp_rd", 32'(bus.res_rd_o), 32'(rd));
      chk("resp_zero", 32'(bus.res_zero_o), 32'(er == 8'h00));
      chk("resp_busy", 32'(bus.cmd_ready_o), 32'd0);
      chk("resp_a_hold", 32'(bus.alu_a_o), 32'(ea));
      res = bus.res_data_o;
      for (int i = 0; i < stall; i++) begin
         if (pulse) begin
            scramble_cmd();
            bus.cmd_valid_i = 1'b1;
         end
         tick();
         bus.cmd_valid_i = 1'b0;
         chk("hold_valid", 32'(bus.res_valid_o), 32'd1);
         chk("hold_data", 32'(bus.res_data_o), 32'(er));
         chk("hold_rd", 32'(bus.res_rd_o), 32'(rd));
         chk("hold_busy", 32'(bus.cmd_ready_o), 32'd0);
      end
      bus.res_ready_i = 1'b1;
      tick();
      bus.res_ready_i = 1'b0;
      chk("hs_valid", 32'(bus.res_valid_o), 32'd0);
      chk("hs_ready", 32'(bus.cmd_ready_o), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] r;
      bus.cmd_valid_i = 1'b0;
      bus.res_ready_i = 1'b0;
      scramble_cmd();
      do_reset();

      chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("rst_valid", 32'(bus.res_valid_o), 32'd0);
      chk("rst_zero", 32'(bus.res_zero_o), 32'd1);
      chk("rst_data", 32'(bus.res_data_o), 32'd0);
      chk("rst_a", 32'(bus.alu_a_o), 32'd0);
      chk_rf();

      do_ld(2'd0, 8'h05);
      do_ld(2'd1, 8'h03);
      chk_rf();

      do_alu(OP_ADD, 2'd2, 2'd0, 2'd1, 0, 1'b0, r);
      chk("add_res", 32'(r), 32'h08);
      do_alu(OP_SUB, 2'd3, 2'd1, 2'd0, 0, 1'b0, r);
      chk("sub_wrap", 32'(r), 32'hFE);
      do_alu(OP_EQ, 2'd0, 2'd1, 2'd1, 0, 1'b0, r);
      chk("eq_res", 32'(r), 32'h01);
      chk("eq_r0", 32'(dut.u_rf.mem[0]), 32'h01);

      do_alu(OP_XOR, 2'd3, 2'd1, 2'd1, 4, 1'b1, r);
      chk("xor_zero", 32'(r), 32'h00);
      chk_rf();

      do_ld(2'd0, 8'h81);
      do_alu(OP_ADD, 2'd0, 2'd0, 2'd0, 1, 1'b0, r);
      chk("rmw_add", 32'(r), 32'h02);
      do_alu(OP_OR, 2'd1, 2'd0, 2'd0, 0, 1'b0, r);
      chk("rmw_or", 32'(r), 32'h02);
      chk_rf();

      // Reset lands while the ADD is in S_EXEC.
      bus.cmd_valid_i = 1'b1;
      bus.cmd_ld_i    = 1'b0;
      bus.cmd_op_i    = OP_ADD;
      bus.cmd_rd_i    = 2'd2;
      bus.cmd_rs1_i   = 2'd0;
      bus.cmd_rs2_i   = 2'd1;
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("mid_exec_busy", 32'(bus.cmd_ready_o), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NREGS; i++) mdl_rf[i] = 8'h00;
      chk("mid_rst_valid", 32'(bus.res_valid_o), 32'd0);
      chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
      chk("mid_rst_data", 32'(bus.res_data_o), 32'd0);
      chk("mid_rst_zero", 32'(bus.res_zero_o), 32'd1);
      chk("mid_rst_b", 32'(bus.alu_b_o), 32'd0);
      chk_rf();
      tick();
      chk("post_rst_valid", 32'(bus.res_valid_o), 32'd0);
      chk_rf();

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_ld(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         end else begin
            do_alu(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
         end
         if (n % 50 == 49) chk_rf();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
